// File: rtl/period_seq_pkg.sv
// Shared types and constants for the period sequencer: FSM state encoding,
// the packed command word stored in the FIFO, and sizing constants.
package period_seq_pkg;

  localparam int MAX    = 32;                 // counter range
  localparam int CW     = $clog2(MAX);        // period (match value) width
  localparam int REPW   = 8;                  // repeat-count width
  localparam int DEPTH  = 4;                  // command FIFO depth, power of two
  localparam int CNT_W  = $clog2(DEPTH) + 1;  // FIFO occupancy width
  localparam int CMD_W  = CW + REPW;          // packed command width
  localparam int STAT_W = 16;                 // completed-command counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  // "repeat" is a keyword, so the repeat field is called repeats.
  typedef struct packed {
    logic [CW-1:0]   period;
    logic [REPW-1:0] repeats;
  } cmd_t;

endpackage

// File: rtl/period_sequencer_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a
// single-cycle flush. Writes into a full FIFO and reads from an empty FIFO
// are ignored.
module fifo_sync #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_full    = (r_count == CNTW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_do_wr   = i_wr_en & ~o_full & ~i_flush;
  assign w_do_rd   = i_rd_en & ~o_empty & ~i_flush;

  // Storage array write port.
  // NOTE: the array has no reset; pointers and count decide which words are valid.
  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/period_sequencer.sv
// Period sequencer: queues {period, repeat} commands and drives a
// load/clear match counter so queued periods run back-to-back.
// Optional feature macro: PERIOD_SEQ_STATS_EN enables the saturating
// completed-command counter on o_cmd_count; without it o_cmd_count is 0.
module period_sequencer
  import period_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [CW-1:0]     i_cmd_period,
  input  logic [REPW-1:0]   i_cmd_repeat,
  input  logic              i_abort,
  output logic              o_cnt_clear,
  output logic              o_cnt_load,
  output logic [CW-1:0]     o_cnt_loadval,
  input  logic              i_cnt_done,
  output logic              o_period_pulse,
  output logic              o_cmd_done,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_fifo_count,
  output logic [STAT_W-1:0] o_cmd_count
);

  state_t          r_state;
  logic [CW-1:0]   r_cur_period;
  logic [REPW-1:0] r_rep_left;
  logic            r_period_pulse;
  logic            r_cmd_done;

  cmd_t            w_push_cmd;
  cmd_t            w_head_cmd;
  logic            w_push;
  logic            w_pop;
  logic            w_last_done;
  logic            w_fifo_full;
  logic            w_fifo_empty;

  assign w_push_cmd.period  = i_cmd_period;
  assign w_push_cmd.repeats = i_cmd_repeat;

  // Abort blocks acceptance so a command offered in the abort cycle is dropped.
  assign o_cmd_ready = ~w_fifo_full & ~i_abort;
  assign w_push      = i_cmd_valid & o_cmd_ready;

  // Final period of the active command completes this cycle.
  assign w_last_done = (r_state == RUN) & i_cnt_done & (r_rep_left == '0);

  // Pop from IDLE, or chain straight into the next command on the last done.
  // The pop looks at the registered count, so a same-cycle push is not seen.
  assign w_pop = ~i_abort & ~w_fifo_empty & ((r_state == IDLE) | w_last_done);

  fifo_sync #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (i_abort),
    .i_wr_en   (w_push),
    .i_wr_data (w_push_cmd),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head_cmd),
    .o_count   (o_fifo_count),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // Counter controls decoded from state; abort also clears the counter.
  assign o_cnt_clear    = (r_state == START) | i_abort;
  assign o_cnt_load     = (r_state == START);
  assign o_cnt_loadval  = (r_state == START) ? r_cur_period : '0;
  assign o_busy         = (r_state != IDLE);
  assign o_period_pulse = r_period_pulse;
  assign o_cmd_done     = r_cmd_done;

  // Sequencing FSM with registered completion pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_cur_period   <= '0;
      r_rep_left     <= '0;
      r_period_pulse <= 1'b0;
      r_cmd_done     <= 1'b0;
    end else begin
      r_period_pulse <= 1'b0;
      r_cmd_done     <= 1'b0;
      if (i_abort) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pop) begin
              r_cur_period <= w_head_cmd.period;
              r_rep_left   <= w_head_cmd.repeats;
              r_state      <= START;
            end
          end
          START: begin
            r_state <= RUN;
          end
          RUN: begin
            if (i_cnt_done) begin
              r_period_pulse <= 1'b1;
              if (r_rep_left != '0) begin
                // The counter wraps on its own; only the repeat budget moves.
                r_rep_left <= r_rep_left - REPW'(1);
              end else begin
                r_cmd_done <= 1'b1;
                if (w_pop) begin
                  r_cur_period <= w_head_cmd.period;
                  r_rep_left   <= w_head_cmd.repeats;
                  r_state      <= START;
                end else begin
                  r_state <= IDLE;
                end
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef PERIOD_SEQ_STATS_EN
  logic [STAT_W-1:0] r_cmd_count;

  // Saturating count of completed commands; only reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_count <= '0;
    end else if (w_last_done && !i_abort && (r_cmd_count != '1)) begin
      r_cmd_count <= r_cmd_count + STAT_W'(1);
    end
  end

  assign o_cmd_count = r_cmd_count;
`else
  assign o_cmd_count = '0;
`endif

endmodule

// File: tb/tb_period_sequencer.sv
// Self-checking bench for period_sequencer. A behavioural match counter
// answers the sequencer's clear/load controls; expected outputs come from a
// timeline model computed arithmetically from each command's accept cycle.
module tb_period_sequencer;
  import period_seq_pkg::*;

`ifdef PERIOD_SEQ_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_cmd_valid = 1'b0;
  logic              o_cmd_ready;
  logic [CW-1:0]     i_cmd_period = '0;
  logic [REPW-1:0]   i_cmd_repeat = '0;
  logic              i_abort = 1'b0;
  logic              o_cnt_clear;
  logic              o_cnt_load;
  logic [CW-1:0]     o_cnt_loadval;
  logic              i_cnt_done;
  logic              o_period_pulse;
  logic              o_cmd_done;
  logic              o_busy;
  logic [CNT_W-1:0]  o_fifo_count;
  logic [STAT_W-1:0] o_cmd_count;

  period_sequencer dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_period   (i_cmd_period),
    .i_cmd_repeat   (i_cmd_repeat),
    .i_abort        (i_abort),
    .o_cnt_clear    (o_cnt_clear),
    .o_cnt_load     (o_cnt_load),
    .o_cnt_loadval  (o_cnt_loadval),
    .i_cnt_done     (i_cnt_done),
    .o_period_pulse (o_period_pulse),
    .o_cmd_done     (o_cmd_done),
    .o_busy         (o_busy),
    .o_fifo_count   (o_fifo_count),
    .o_cmd_count    (o_cmd_count)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural load/clear match counter: wraps to 0 after reaching match.
  logic [CW-1:0] env_cnt, env_match;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      env_cnt   <= '0;
      env_match <= '0;
    end else begin
      if (o_cnt_clear || env_cnt == env_match) env_cnt <= '0;
      else env_cnt <= env_cnt + 1'b1;
      if (o_cnt_load) env_match <= o_cnt_loadval;
    end
  end
  assign i_cnt_done = (env_cnt == env_match);

  int n_cmp = 0;
  int n_bad = 0;
  int exp_total = 0;

  // Scenario description and derived timeline.
  int sc_n;
  int sc_p[16], sc_r[16], sc_want[16];
  int t_acc[16], s_start[16], e_end[16];

  // Queued commands at cycle c among the first 'upto' commands.
  function automatic int occ_at(int c, int upto);
    int o = 0;
    for (int j = 0; j < upto; j++) begin
      if (t_acc[j] < c) o++;
      if (s_start[j] - 1 < c) o--;
    end
    return o;
  endfunction

  // Accept, START and end (last pulse) cycles of every command.
  task automatic plan();
    for (int i = 0; i < sc_n; i++) begin
      int t;
      int s;
      t = (i == 0) ? sc_want[0] : ((sc_want[i] > t_acc[i-1] + 1) ? sc_want[i] : t_acc[i-1] + 1);
      while (occ_at(t, i) >= DEPTH) t++;
      t_acc[i] = t;
      s = t + 2;
      if (i > 0 && e_end[i-1] > s) s = e_end[i-1];
      s_start[i] = s;
      e_end[i] = s + 2 + sc_p[i] + sc_r[i] * (sc_p[i] + 1);
    end
  endtask

  task automatic run_scenario(input string name);
    int h, ai;
    plan();
    h = e_end[sc_n-1] + 3;
    ai = 0;
    @(posedge i_clk); #1;
    for (int c = 0; c <= h; c++) begin
      bit e_pulse, e_done, e_busy, e_start, e_ready;
      int e_occ, e_lv, e_stats;
      i_cmd_valid = (ai < sc_n) && (c >= sc_want[ai]);
      if (ai < sc_n) begin
        i_cmd_period = CW'(sc_p[ai]);
        i_cmd_repeat = REPW'(sc_r[ai]);
      end
      e_pulse = 0; e_done = 0; e_busy = 0; e_start = 0; e_lv = 0; e_stats = exp_total;
      for (int j = 0; j < sc_n; j++) begin
        int d;
        d = c - (s_start[j] + 2 + sc_p[j]);
        if (d >= 0 && d % (sc_p[j] + 1) == 0 && d / (sc_p[j] + 1) <= sc_r[j]) e_pulse = 1;
        if (c == e_end[j]) e_done = 1;
        if (c >= s_start[j] && c < e_end[j]) e_busy = 1;
        if (c == s_start[j]) begin e_start = 1; e_lv = sc_p[j]; end
        if (e_end[j] <= c) e_stats++;
      end
      if (e_stats > 65535) e_stats = 65535;
      if (!STATS_EN) e_stats = 0;
      e_occ = occ_at(c, sc_n);
      e_ready = (e_occ < DEPTH);
      @(negedge i_clk);
      n_cmp++; if (o_cmd_ready !== e_ready) begin n_bad++; $display("FAIL %s ready c=%0d got %b exp %b", name, c, o_cmd_ready, e_ready); end
      n_cmp++; if (o_fifo_count !== CNT_W'(e_occ)) begin n_bad++; $display("FAIL %s fifo_count c=%0d got %0d exp %0d", name, c, o_fifo_count, e_occ); end
      n_cmp++; if (o_busy !== e_busy) begin n_bad++; $display("FAIL %s busy c=%0d got %b exp %b", name, c, o_busy, e_busy); end
      n_cmp++; if (o_cnt_clear !== e_start) begin n_bad++; $display("FAIL %s clear c=%0d got %b exp %b", name, c, o_cnt_clear, e_start); end
      n_cmp++; if (o_cnt_load !== e_start) begin n_bad++; $display("FAIL %s load c=%0d got %b exp %b", name, c, o_cnt_load, e_start); end
      n_cmp++; if (o_cnt_loadval !== CW'(e_lv)) begin n_bad++; $display("FAIL %s loadval c=%0d got %0d exp %0d", name, c, o_cnt_loadval, e_lv); end
      n_cmp++; if (o_period_pulse !== e_pulse) begin n_bad++; $display("FAIL %s period_pulse c=%0d got %b exp %b", name, c, o_period_pulse, e_pulse); end
      n_cmp++; if (o_cmd_done !== e_done) begin n_bad++; $display("FAIL %s cmd_done c=%0d got %b exp %b", name, c, o_cmd_done, e_done); end
      n_cmp++; if (o_cmd_count !== STAT_W'(e_stats)) begin n_bad++; $display("FAIL %s cmd_count c=%0d got %0d exp %0d", name, c, o_cmd_count, e_stats); end
      if (ai < sc_n && c == t_acc[ai]) ai++;
      @(posedge i_clk); #1;
    end
    i_cmd_valid = 1'b0;
    exp_total += sc_n;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset ready got %b exp 1", o_cmd_ready); end
    n_cmp++; if ({o_cnt_clear, o_cnt_load, o_period_pulse, o_cmd_done, o_busy} !== 5'b0) begin n_bad++; $display("FAIL reset flags got %b exp 00000", {o_cnt_clear, o_cnt_load, o_period_pulse, o_cmd_done, o_busy}); end
    n_cmp++; if (o_fifo_count !== '0 || o_cnt_loadval !== '0) begin n_bad++; $display("FAIL reset count/loadval got %0d/%0d exp 0/0", o_fifo_count, o_cnt_loadval); end
    n_cmp++; if (o_cmd_count !== '0) begin n_bad++; $display("FAIL reset cmd_count got %0d exp 0", o_cmd_count); end
    i_rst_n = 1'b1;
    exp_total = 0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_single();
    sc_n = 1; sc_p[0] = 5; sc_r[0] = 0; sc_want[0] = 10;
    run_scenario("single");
  endtask

  task automatic test_repeat();
    sc_n = 1; sc_p[0] = 3; sc_r[0] = 2; sc_want[0] = 1;
    run_scenario("repeat");
  endtask

  task automatic test_p_zero();
    sc_n = 1; sc_p[0] = 0; sc_r[0] = 3; sc_want[0] = 0;
    run_scenario("p_zero");
  endtask

  task automatic test_back_to_back();
    sc_n = 6;
    for (int i = 0; i < sc_n; i++) begin
      sc_p[i] = 2 + i; sc_r[i] = i % 2; sc_want[i] = i;
    end
    run_scenario("back_to_back");
  endtask

  task automatic test_full_repeat();
    sc_n = 2;
    sc_p[0] = 0; sc_r[0] = (1 << REPW) - 1; sc_want[0] = 0;
    sc_p[1] = MAX - 1; sc_r[1] = 0; sc_want[1] = 3;
    run_scenario("full_repeat");
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      int w = 0;
      sc_n = $urandom_range(2, 7);
      for (int i = 0; i < sc_n; i++) begin
        w += $urandom_range(0, 12);
        sc_want[i] = w;
        sc_p[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX - 1) : $urandom_range(0, 6);
        sc_r[i] = $urandom_range(0, 3);
      end
      run_scenario("random");
    end
  endtask

  task automatic test_abort();
    @(posedge i_clk); #1;
    for (int c = 0; c <= 30; c++) begin
      i_cmd_valid = 1'b0; i_abort = 1'b0;
      case (c)
        0: begin i_cmd_valid = 1'b1; i_cmd_period = 5'd6; i_cmd_repeat = 8'd3; end
        1: begin i_cmd_valid = 1'b1; i_cmd_period = 5'd3; i_cmd_repeat = 8'd1; end
        2: begin i_cmd_valid = 1'b1; i_cmd_period = 5'd2; i_cmd_repeat = 8'd0; end
        9: begin i_abort = 1'b1; i_cmd_valid = 1'b1; i_cmd_period = 5'd1; i_cmd_repeat = 8'd0; end
        default: ;
      endcase
      @(negedge i_clk);
      if (c < 9) begin
        n_cmp++; if (o_cmd_done !== 1'b0) begin n_bad++; $display("FAIL abort early_done c=%0d got %b exp 0", c, o_cmd_done); end
      end else if (c == 9) begin
        n_cmp++; if (o_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL abort ready got %b exp 0", o_cmd_ready); end
        n_cmp++; if (o_cnt_clear !== 1'b1) begin n_bad++; $display("FAIL abort clear got %b exp 1", o_cnt_clear); end
        n_cmp++; if (o_fifo_count !== CNT_W'(2)) begin n_bad++; $display("FAIL abort queued got %0d exp 2", o_fifo_count); end
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL abort busy_before got %b exp 1", o_busy); end
      end else begin
        n_cmp++; if (o_period_pulse !== 1'b0 || o_cmd_done !== 1'b0) begin n_bad++; $display("FAIL abort pulses c=%0d got %b%b exp 00", c, o_period_pulse, o_cmd_done); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL abort busy c=%0d got %b exp 0", c, o_busy); end
        n_cmp++; if (o_fifo_count !== '0) begin n_bad++; $display("FAIL abort fifo_count c=%0d got %0d exp 0", c, o_fifo_count); end
        n_cmp++; if (o_cnt_clear !== 1'b0) begin n_bad++; $display("FAIL abort clear_after c=%0d got %b exp 0", c, o_cnt_clear); end
        n_cmp++; if (o_cmd_count !== STAT_W'(STATS_EN ? exp_total : 0)) begin n_bad++; $display("FAIL abort cmd_count c=%0d got %0d exp %0d", c, o_cmd_count, STATS_EN ? exp_total : 0); end
      end
      @(posedge i_clk); #1;
    end
    i_cmd_valid = 1'b0; i_abort = 1'b0;
  endtask

  task automatic test_stats();
    #2 i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_total = 0;
    sc_n = 3;
    for (int i = 0; i < 3; i++) begin
      sc_p[i] = 1 + i; sc_r[i] = 1; sc_want[i] = 2 * i;
    end
    run_scenario("stats");
    @(negedge i_clk);
    n_cmp++; if (o_cmd_count !== STAT_W'(STATS_EN ? 3 : 0)) begin n_bad++; $display("FAIL stats final got %0d exp %0d", o_cmd_count, STATS_EN ? 3 : 0); end
  endtask

  task automatic test_reset_mid();
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b1; i_cmd_period = 5'd7; i_cmd_repeat = 8'd5;
    @(posedge i_clk); #1;
    i_cmd_period = 5'd4; i_cmd_repeat = 8'd2;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    repeat (6) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_busy !== 1'b0 || o_fifo_count !== '0) begin n_bad++; $display("FAIL reset_mid state got busy=%b count=%0d exp 0/0", o_busy, o_fifo_count); end
    n_cmp++; if (o_cmd_ready !== 1'b1 || o_cnt_clear !== 1'b0 || o_cnt_load !== 1'b0) begin n_bad++; $display("FAIL reset_mid ctrl got rdy=%b clr=%b ld=%b exp 1/0/0", o_cmd_ready, o_cnt_clear, o_cnt_load); end
    n_cmp++; if (o_cmd_count !== '0) begin n_bad++; $display("FAIL reset_mid cmd_count got %0d exp 0", o_cmd_count); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_total = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      n_cmp++; if (o_busy !== 1'b0 || o_period_pulse !== 1'b0 || o_cmd_done !== 1'b0 || o_fifo_count !== '0) begin
        n_bad++; $display("FAIL reset_mid after c=%0d got busy=%b pp=%b done=%b cnt=%0d exp all 0", c, o_busy, o_period_pulse, o_cmd_done, o_fifo_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_p_zero();
    test_back_to_back();
    test_full_repeat();
    test_random();
    test_abort();
    test_stats();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
